// File: rtl/gray_counter_ud.sv
// Parametrised up/down Gray-code counter with load, clear, wrap/saturate, terminal count and overflow pulse.
// Gray output comes straight from flops; with MAX_COUNT < 2**WIDTH-1 the wrap step may flip several bits.
module gray_counter_ud #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] bin_next;
  logic             ovf_next;

  // Next-count selection: clr > load > en; end-of-range steps wrap or hold and raise ovf.
  always_comb begin
    bin_next = bin;
    ovf_next = 1'b0;
    if (clr) begin
      bin_next = ZERO;
    end else if (load) begin
      bin_next = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (bin == MAX_COUNT) begin
          bin_next = SATURATE ? MAX_COUNT : ZERO;
          ovf_next = 1'b1;
        end else begin
          bin_next = bin + ONE;
        end
      end else begin
        if (bin == ZERO) begin
          bin_next = SATURATE ? ZERO : MAX_COUNT;
          ovf_next = 1'b1;
        end else begin
          bin_next = bin - ONE;
        end
      end
    end
  end

  // Gray register is loaded from the converted next value so out and bin always match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin <= RESET_VALUE;
      out <= RESET_VALUE ^ (RESET_VALUE >> 1);
      ovf <= 1'b0;
    end else begin
      bin <= bin_next;
      out <= bin_next ^ (bin_next >> 1);
      ovf <= ovf_next;
    end
  end

  assign tc = up_dn ? (bin == MAX_COUNT) : (bin == ZERO);

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: four 4-bit configurations driven in parallel, checked against
// directed vector tables, hand-written corner sequences and an arithmetic reference model.
module tb_gray_counter_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] bin_w[4];
  logic [3:0] out_w[4];
  logic       ovf_w[4];
  logic       tc_w[4];

  gray_counter_ud #(.WIDTH(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .out(out_w[0]), .bin(bin_w[0]), .tc(tc_w[0]), .ovf(ovf_w[0]));
  gray_counter_ud #(.WIDTH(4), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .out(out_w[1]), .bin(bin_w[1]), .tc(tc_w[1]), .ovf(ovf_w[1]));
  gray_counter_ud #(.WIDTH(4), .MAX_COUNT(4'd9)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .out(out_w[2]), .bin(bin_w[2]), .tc(tc_w[2]), .ovf(ovf_w[2]));
  gray_counter_ud #(.WIDTH(4), .RESET_VALUE(4'd5)) u3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .out(out_w[3]), .bin(bin_w[3]), .tc(tc_w[3]), .ovf(ovf_w[3]));

  typedef struct {
    bit clr, load, en, up;
    logic [3:0] lv;
    logic [3:0] e_bin, e_out;
    bit e_ovf, e_tc;
  } vec_t;

  // Reflected binary code for 0..15, written out as constants.
  logic [3:0] gtab[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  int maxc[4] = '{15, 15, 9, 15};
  bit sat[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  int rstv[4] = '{0, 0, 0, 5};

  int m_bin[4];
  bit m_ovf[4];
  bit m_up;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference step: move the count by +/-1 as an integer, then fold out-of-range results.
  function automatic void model_step(bit c, bit l, bit e, bit u, int lv);
    m_up = u;
    for (int k = 0; k < 4; k++) begin
      int tgt;
      m_ovf[k] = 1'b0;
      if (c) m_bin[k] = 0;
      else if (l) m_bin[k] = (lv > maxc[k]) ? maxc[k] : lv;
      else if (e) begin
        tgt = u ? m_bin[k] + 1 : m_bin[k] - 1;
        if (tgt < 0 || tgt > maxc[k]) begin
          m_ovf[k] = 1'b1;
          if (!sat[k]) m_bin[k] = (tgt + maxc[k] + 1) % (maxc[k] + 1);
        end else begin
          m_bin[k] = tgt;
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      bit etc;
      etc = m_up ? (m_bin[k] == maxc[k]) : (m_bin[k] == 0);
      chk($sformatf("u%0d bin", k), 32'(bin_w[k]), 32'(m_bin[k]));
      chk($sformatf("u%0d out", k), 32'(out_w[k]), 32'(gtab[m_bin[k]]));
      chk($sformatf("u%0d ovf", k), 32'(ovf_w[k]), 32'(m_ovf[k]));
      chk($sformatf("u%0d tc", k), 32'(tc_w[k]), 32'(etc));
    end
  endtask

  task automatic cycle(input bit c, input bit l, input bit e, input bit u, input logic [3:0] lv);
    logic [3:0] prev;
    prev = out_w[0];
    clr = c; load = l; en = e; up_dn = u; load_val = lv;
    @(posedge clk);
    #1;
    model_step(c, l, e, u, int'(lv));
    check_all();
    if (e && !c && !l) chk("u0 gray one-bit step", 32'($countones(out_w[0] ^ prev)), 32'd1);
  endtask

  // Reset pulse placed strictly between clock edges; outputs must follow without an edge.
  task automatic arst();
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      m_bin[k] = rstv[k];
      m_ovf[k] = 1'b0;
    end
    m_up = up_dn;
    check_all();
    chk("async rst u3 bin", 32'(bin_w[3]), 32'd5);
    chk("async rst u3 out", 32'(out_w[3]), 32'b0111);
    chk("async rst u3 ovf", 32'(ovf_w[3]), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  function automatic vec_t mkv(bit c, bit l, bit e, bit u, int lv, int b, bit o, bit t);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.lv = 4'(lv);
    v.e_bin = 4'(b); v.e_out = gtab[b]; v.e_ovf = o; v.e_tc = t;
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    m_up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_bin[k] = rstv[k];
      m_ovf[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Directed vectors for the full-range wrapping instance.
    for (int i = 1; i <= 20; i++) tbl.push_back(mkv(0, 0, 1, 1, 0, i % 16, i == 16, (i % 16) == 15));
    tbl.push_back(mkv(0, 1, 0, 0, 3, 3, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 2, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 15, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 14, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 1, 9, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 9, 9, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 9, 0, 0));
    foreach (tbl[i]) begin
      cycle(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv);
      chk($sformatf("tbl[%0d] bin", i), 32'(bin_w[0]), 32'(tbl[i].e_bin));
      chk($sformatf("tbl[%0d] out", i), 32'(out_w[0]), 32'(tbl[i].e_out));
      chk($sformatf("tbl[%0d] ovf", i), 32'(ovf_w[0]), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl[%0d] tc", i), 32'(tc_w[0]), 32'(tbl[i].e_tc));
    end

    // Saturating instance: blocked steps hold the count and pulse ovf every cycle.
    cycle(0, 1, 0, 1, 14);
    chk("sat load bin", 32'(bin_w[1]), 32'd14);
    cycle(0, 0, 1, 1, 0);
    chk("sat up bin", 32'(bin_w[1]), 32'd15); chk("sat up ovf", 32'(ovf_w[1]), 32'd0);
    chk("sat up tc", 32'(tc_w[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 1, 0);
      chk("sat hold hi bin", 32'(bin_w[1]), 32'd15); chk("sat hold hi ovf", 32'(ovf_w[1]), 32'd1);
      chk("sat hold hi out", 32'(out_w[1]), 32'b1000);
    end
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    chk("sat dn bin", 32'(bin_w[1]), 32'd0); chk("sat dn ovf", 32'(ovf_w[1]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0, 0);
      chk("sat hold lo bin", 32'(bin_w[1]), 32'd0); chk("sat hold lo ovf", 32'(ovf_w[1]), 32'd1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("sat idle ovf", 32'(ovf_w[1]), 32'd0);

    // Reduced modulus: 9 wraps to 0, loads above 9 clip, 0 down wraps to 9.
    cycle(0, 1, 0, 1, 8);
    cycle(0, 0, 1, 1, 0);
    chk("mod9 bin 9", 32'(bin_w[2]), 32'd9); chk("mod9 tc", 32'(tc_w[2]), 32'd1);
    cycle(0, 0, 1, 1, 0);
    chk("mod9 wrap bin", 32'(bin_w[2]), 32'd0); chk("mod9 wrap ovf", 32'(ovf_w[2]), 32'd1);
    cycle(0, 0, 1, 1, 0);
    chk("mod9 ovf drop", 32'(ovf_w[2]), 32'd0);
    cycle(0, 1, 0, 1, 12);
    chk("mod9 clip bin", 32'(bin_w[2]), 32'd9); chk("mod9 clip out", 32'(out_w[2]), 32'b1101);
    cycle(0, 0, 1, 1, 0);
    chk("mod9 wrap2 bin", 32'(bin_w[2]), 32'd0);
    cycle(0, 0, 1, 0, 0);
    chk("mod9 dn wrap bin", 32'(bin_w[2]), 32'd9); chk("mod9 dn wrap ovf", 32'(ovf_w[2]), 32'd1);

    // Mid-count asynchronous reset, then counting resumes from the reset value.
    cycle(0, 1, 0, 1, 2);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    arst();
    cycle(0, 0, 1, 1, 0);
    chk("post rst u3 bin", 32'(bin_w[3]), 32'd6);
    chk("post rst u0 bin", 32'(bin_w[0]), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      bit c, l, e, u;
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = ($urandom_range(0, 3) != 0) ^ (i >= 300);
      cycle(c, l, e, u, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) arst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
